// File: rtl/axi_wr_scheduler.sv
// AXI4 write-burst scheduler: round-robin between two requesters, one burst
// in flight at a time, with a bounded wait for the write response.
module axi_wr_scheduler #(
    parameter int unsigned ADDR_W    = 29,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned B_TIMEOUT = 1023
) (
    input  logic                eth_rxck,
    input  logic                rst_rx,

    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [7:0]          req0_len,
    output logic                req0_ack,
    input  logic [DATA_W-1:0]   wr0_data,
    input  logic                wr0_valid,
    output logic                wr0_ready,
    output logic                done0,
    output logic                err0,

    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [7:0]          req1_len,
    output logic                req1_ack,
    input  logic [DATA_W-1:0]   wr1_data,
    input  logic                wr1_valid,
    output logic                wr1_ready,
    output logic                done1,
    output logic                err1,

    output logic [1:0]          M_AXI_AWID,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [7:0]          M_AXI_AWLEN,
    output logic [2:0]          M_AXI_AWSIZE,
    output logic [1:0]          M_AXI_AWBURST,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WLAST,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic                M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned BCNT_W = $clog2(B_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_t;

    state_t              state;
    logic                last_grant;
    logic                gnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          beat_cnt;
    logic [BCNT_W-1:0]   b_cnt;

    logic                pick1;
    logic                in_w;
    logic                w_hs;
    logic                w_last;

    // Tie goes to whichever requester was not served last.
    assign pick1 = req1_valid && (!req0_valid || !last_grant);

    assign in_w   = (state == S_W);
    assign w_last = (beat_cnt == len_q);
    assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;

    assign M_AXI_AWVALID = (state == S_AW);
    assign M_AXI_AWID    = {1'b0, gnt_q};
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = len_q;
    assign M_AXI_AWSIZE  = 3'($clog2(STRB_W));
    assign M_AXI_AWBURST = 2'b01;

    // Data channel is a straight mux from the granted requester.
    assign M_AXI_WVALID = in_w && (gnt_q ? wr1_valid : wr0_valid);
    assign M_AXI_WDATA  = gnt_q ? wr1_data : wr0_data;
    assign M_AXI_WSTRB  = {STRB_W{1'b1}};
    assign M_AXI_WLAST  = in_w && w_last;
    assign wr0_ready    = in_w && !gnt_q && M_AXI_WREADY;
    assign wr1_ready    = in_w &&  gnt_q && M_AXI_WREADY;

    assign M_AXI_BREADY = (state == S_B);

    always_ff @(posedge eth_rxck) begin
        if (rst_rx) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            gnt_q      <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            b_cnt      <= '0;
            req0_ack   <= 1'b0;
            req1_ack   <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        gnt_q      <= pick1;
                        last_grant <= pick1;
                        addr_q     <= pick1 ? req1_addr : req0_addr;
                        len_q      <= pick1 ? req1_len : req0_len;
                        req0_ack   <= !pick1;
                        req1_ack   <= pick1;
                        state      <= S_AW;
                    end
                end
                S_AW: begin
                    if (M_AXI_AWREADY) begin
                        beat_cnt <= '0;
                        state    <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (w_last) begin
                            b_cnt <= '0;
                            state <= S_B;
                        end
                    end
                end
                S_B: begin
                    // A response in the final wait cycle still wins over the timeout.
                    if (M_AXI_BVALID) begin
                        done0 <= !gnt_q;
                        done1 <= gnt_q;
                        err0  <= !gnt_q && M_AXI_BRESP;
                        err1  <= gnt_q && M_AXI_BRESP;
                        state <= S_IDLE;
                    end else if (b_cnt == BCNT_W'(B_TIMEOUT - 1)) begin
                        done0 <= !gnt_q;
                        done1 <= gnt_q;
                        err0  <= !gnt_q;
                        err1  <= gnt_q;
                        state <= S_IDLE;
                    end else begin
                        b_cnt <= b_cnt + BCNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Bench for axi_wr_scheduler: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a burst-level reference model.
module tb_axi_wr_scheduler;

    localparam int unsigned TOUT = 15;

    logic        eth_rxck = 1'b0;
    logic        rst_rx;
    logic        req0_valid, req1_valid;
    logic [28:0] req0_addr, req1_addr;
    logic [7:0]  req0_len, req1_len;
    logic        req0_ack, req1_ack;
    logic [31:0] wr0_data, wr1_data;
    logic        wr0_valid, wr1_valid;
    logic        wr0_ready, wr1_ready;
    logic        done0, done1, err0, err1;
    logic [1:0]  M_AXI_AWID;
    logic [28:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BRESP, M_AXI_BVALID, M_AXI_BREADY;

    always #5 eth_rxck = ~eth_rxck;

    axi_wr_scheduler #(.ADDR_W(29), .DATA_W(32), .B_TIMEOUT(TOUT)) dut (
        .eth_rxck(eth_rxck), .rst_rx(rst_rx),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ack(req0_ack),
        .wr0_data(wr0_data), .wr0_valid(wr0_valid), .wr0_ready(wr0_ready),
        .done0(done0), .err0(err0),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ack(req1_ack),
        .wr1_data(wr1_data), .wr1_valid(wr1_valid), .wr1_ready(wr1_ready),
        .done1(done1), .err1(err1),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus knobs
    bit          auto_req = 0;
    bit          rst_req  = 1;
    int unsigned p_req = 40, p_wv = 100, p_aw = 100, p_wr = 100, p_b = 100;
    int unsigned bresp_mode = 0;
    int unsigned aw_delay = 0;
    bit          wtoggle = 0;
    bit          want_v[2], once[2];
    logic [28:0] want_a[2];
    logic [7:0]  want_l[2];
    bit          rv[2];
    logic [28:0] ra[2];
    logic [7:0]  rl[2];

    // Reference model: burst-level progress of the single outstanding burst
    bit          known = 0;
    bit          inflight, aw_done, w_done;
    int          gid, beats, bcyc;
    logic [28:0] g_addr;
    logic [7:0]  g_len;
    bit          last_grant;
    bit [1:0]    exp_ack, exp_done, exp_err;

    // Observation counters for the directed scenarios
    int aw_cyc, aw_hs, beats_obs, wlast_obs, bready_cyc, doneerr1;
    int done_cnt[2], err_cnt[2];
    int ack_log[$];
    int aw_run = 0;
    bit ack_seen[2];

    function automatic logic [7:0] rand_len();
        int unsigned r = $urandom % 32;
        if (r == 0) return 8'd255;
        return 8'($urandom % 8);
    endfunction

    task automatic clear_counters();
        aw_cyc = 0; aw_hs = 0; beats_obs = 0; wlast_obs = 0; bready_cyc = 0; doneerr1 = 0;
        done_cnt[0] = 0; done_cnt[1] = 0; err_cnt[0] = 0; err_cnt[1] = 0;
        ack_log.delete();
    endtask

    task automatic drive();
        rst_rx = rst_req || (auto_req && (($urandom % 800) == 0));
        for (int n = 0; n < 2; n++) begin
            if (auto_req) begin
                if (ack_seen[n]) rv[n] = 0;
                if (!rv[n] && (($urandom % 100) < p_req)) begin
                    rv[n] = 1;
                    ra[n] = 29'($urandom) & ~29'h3;
                    rl[n] = rand_len();
                end
            end else begin
                if (ack_seen[n] && once[n]) want_v[n] = 0;
                rv[n] = want_v[n];
                ra[n] = want_a[n];
                rl[n] = want_l[n];
            end
        end
        req0_valid = rv[0]; req0_addr = ra[0]; req0_len = rl[0];
        req1_valid = rv[1]; req1_addr = ra[1]; req1_len = rl[1];
        wr0_valid = ($urandom % 100) < p_wv;
        wr1_valid = ($urandom % 100) < p_wv;
        wr0_data  = $urandom;
        wr1_data  = $urandom;
        M_AXI_AWREADY = (aw_delay > 0) ? (aw_run >= int'(aw_delay)) : (($urandom % 100) < p_aw);
        M_AXI_WREADY  = wtoggle ? !M_AXI_WREADY : (($urandom % 100) < p_wr);
        M_AXI_BVALID  = ($urandom % 100) < p_b;
        M_AXI_BRESP   = (bresp_mode == 2) ? 1'($urandom) : 1'(bresp_mode);
    endtask

    task automatic sample();
        bit aw_ph, w_ph, b_ph, exp_wv;
        bit [1:0] n_ack, n_done, n_err;
        aw_ph  = inflight && !aw_done;
        w_ph   = inflight && aw_done && !w_done;
        b_ph   = inflight && w_done;
        exp_wv = w_ph && ((gid == 1) ? wr1_valid : wr0_valid);
        if (known) begin
            check("ack0", req0_ack, exp_ack[0]);
            check("ack1", req1_ack, exp_ack[1]);
            check("awvalid", M_AXI_AWVALID, aw_ph);
            if (aw_ph) begin
                check("awid", M_AXI_AWID, gid);
                check("awaddr", M_AXI_AWADDR, g_addr);
                check("awlen", M_AXI_AWLEN, g_len);
                check("awsize", M_AXI_AWSIZE, 2);
                check("awburst", M_AXI_AWBURST, 1);
            end
            check("wvalid", M_AXI_WVALID, exp_wv);
            if (exp_wv) begin
                check("wdata", M_AXI_WDATA, (gid == 1) ? wr1_data : wr0_data);
                check("wstrb", M_AXI_WSTRB, 4'hf);
                check("wlast", M_AXI_WLAST, beats == int'(g_len));
            end
            check("wr0_ready", wr0_ready, w_ph && gid == 0 && M_AXI_WREADY);
            check("wr1_ready", wr1_ready, w_ph && gid == 1 && M_AXI_WREADY);
            check("bready", M_AXI_BREADY, b_ph);
            check("done0", done0, exp_done[0]);
            check("done1", done1, exp_done[1]);
            check("err0", err0, exp_err[0]);
            check("err1", err1, exp_err[1]);
            if (M_AXI_AWVALID) aw_cyc++;
            if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs++;
            if (M_AXI_WVALID && M_AXI_WREADY) beats_obs++;
            if (M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST) wlast_obs++;
            if (M_AXI_BREADY) bready_cyc++;
            if (done0) done_cnt[0]++;
            if (done1) done_cnt[1]++;
            if (err0) err_cnt[0]++;
            if (err1) err_cnt[1]++;
            if (done1 && err1) doneerr1++;
            if (req0_ack) ack_log.push_back(0);
            if (req1_ack) ack_log.push_back(1);
        end
        ack_seen[0] = req0_ack;
        ack_seen[1] = req1_ack;
        aw_run = M_AXI_AWVALID ? aw_run + 1 : 0;

        n_ack = 0; n_done = 0; n_err = 0;
        if (rst_rx) begin
            known = 1; inflight = 0; aw_done = 0; w_done = 0; last_grant = 1;
        end else if (known) begin
            if (!inflight) begin
                if (req0_valid || req1_valid) begin
                    gid = (req0_valid && req1_valid) ? int'(!last_grant) : int'(req1_valid);
                    last_grant = (gid == 1);
                    g_addr = (gid == 1) ? req1_addr : req0_addr;
                    g_len  = (gid == 1) ? req1_len : req0_len;
                    inflight = 1; aw_done = 0; w_done = 0; beats = 0;
                    n_ack[gid] = 1;
                end
            end else if (aw_ph) begin
                if (M_AXI_AWREADY) aw_done = 1;
            end else if (w_ph) begin
                if (exp_wv && M_AXI_WREADY) begin
                    if (beats == int'(g_len)) begin
                        w_done = 1;
                        bcyc = 0;
                    end else begin
                        beats++;
                    end
                end
            end else begin
                bcyc++;
                if (M_AXI_BVALID) begin
                    n_done[gid] = 1; n_err[gid] = M_AXI_BRESP; inflight = 0;
                end else if (bcyc == int'(TOUT)) begin
                    n_done[gid] = 1; n_err[gid] = 1; inflight = 0;
                end
            end
        end
        exp_ack = n_ack; exp_done = n_done; exp_err = n_err;
    endtask

    task automatic step();
        @(posedge eth_rxck);
        #1;
        drive();
        @(negedge eth_rxck);
        sample();
    endtask

    task automatic set_req(input int n, input bit v, input logic [28:0] a, input logic [7:0] l, input bit o);
        want_v[n] = v; want_a[n] = a; want_l[n] = l; once[n] = o;
    endtask

    initial begin
        rst_rx = 1; req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
        req0_len = 0; req1_len = 0; wr0_valid = 0; wr1_valid = 0; wr0_data = 0; wr1_data = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BRESP = 0; M_AXI_BVALID = 0;
        set_req(0, 0, 0, 0, 1);
        set_req(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step();
        rst_req = 0;

        // Single 4-beat burst from requester 0
        clear_counters();
        set_req(0, 1, 29'h100, 8'd3, 1);
        for (int i = 0; i < 20; i++) step();
        check("d1_aw_hs", aw_hs, 1);
        check("d1_beats", beats_obs, 4);
        check("d1_wlast", wlast_obs, 1);
        check("d1_done0", done_cnt[0], 1);
        check("d1_err0", err_cnt[0], 0);

        // Tie after reset: req0, req1, req0
        rst_req = 1; step(); rst_req = 0;
        clear_counters();
        set_req(0, 1, 29'h200, 8'd0, 0);
        set_req(1, 1, 29'h300, 8'd0, 0);
        for (int i = 0; i < 100 && ack_log.size() < 3; i++) step();
        check("d2_nack", ack_log.size(), 3);
        if (ack_log.size() >= 3) begin
            check("d2_first", ack_log[0], 0);
            check("d2_second", ack_log[1], 1);
            check("d2_third", ack_log[2], 0);
        end
        set_req(0, 0, 0, 0, 1);
        set_req(1, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step();

        // Delayed AWREADY, toggling WREADY, single beat
        clear_counters();
        aw_delay = 5; wtoggle = 1;
        set_req(0, 1, 29'h40, 8'd0, 1);
        for (int i = 0; i < 40; i++) step();
        check("d3_aw_cycles", aw_cyc, 6);
        check("d3_aw_hs", aw_hs, 1);
        check("d3_beats", beats_obs, 1);
        check("d3_wlast", wlast_obs, 1);
        aw_delay = 0; wtoggle = 0;

        // Error response on requester 1
        clear_counters();
        bresp_mode = 1;
        set_req(1, 1, 29'h80, 8'd2, 1);
        for (int i = 0; i < 20; i++) step();
        check("d4_done1", done_cnt[1], 1);
        check("d4_doneerr1", doneerr1, 1);
        bresp_mode = 0;

        // Response timeout
        clear_counters();
        p_b = 0;
        set_req(0, 1, 29'hc0, 8'd0, 1);
        for (int i = 0; i < 40; i++) step();
        check("d5_bready", bready_cyc, int'(TOUT));
        check("d5_done0", done_cnt[0], 1);
        check("d5_err0", err_cnt[0], 1);

        // Reset mid-burst, then a fresh req1
        clear_counters();
        set_req(0, 1, 29'h400, 8'd7, 1);
        for (int i = 0; i < 20 && beats_obs < 2; i++) step();
        check("d6_reach_beat2", beats_obs, 2);
        rst_req = 1; step(); rst_req = 0;
        clear_counters();
        p_b = 100;
        set_req(0, 0, 0, 0, 1);
        set_req(1, 1, 29'h500, 8'd0, 1);
        for (int i = 0; i < 20 && ack_log.size() == 0; i++) step();
        check("d6_first_grant", (ack_log.size() > 0) ? ack_log[0] : 99, 1);
        for (int i = 0; i < 20; i++) step();
        check("d6_no_done0", done_cnt[0], 0);
        check("d6_done1", done_cnt[1], 1);

        // Randomized traffic
        auto_req = 1; bresp_mode = 2; p_req = 40;
        for (int b = 0; b < 8; b++) begin
            p_aw = ($urandom % 2) ? 100 : 30;
            p_wr = ($urandom % 2) ? 100 : 50;
            p_wv = ($urandom % 2) ? 100 : 60;
            case ($urandom % 4)
                0: p_b = 0;
                1: p_b = 10;
                2: p_b = 50;
                default: p_b = 100;
            endcase
            for (int i = 0; i < 1000; i++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
